// File: rtl/cfg_sequencer.sv
// Configuration-bus master: buffers a batch of host address/data words and replays the
// whole batch to the layer engine as contiguous cfg_valid beats once the engine is idle.
module cfg_sequencer #(
  parameter int CFG_DWIDTH  = 32,
  parameter int CFG_AWIDTH  = 5,
  parameter int FIFO_AWIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CFG_DWIDTH-1:0]  up_data,
  input  logic [CFG_AWIDTH-1:0]  up_addr,
  input  logic                   up_last,
  input  logic                   up_val,
  output logic                   up_rdy,
  input  logic                   engine_busy,
  output logic [CFG_DWIDTH-1:0]  cfg_data,
  output logic [CFG_AWIDTH-1:0]  cfg_addr,
  output logic                   cfg_valid,
  output logic                   batch_done,
  output logic [FIFO_AWIDTH:0]   batch_len,
  output logic                   err_trunc
);

  // state   | meaning
  // S_FILL  | accepting host words into the batch buffer
  // S_WAIT  | batch closed, waiting for the engine to report idle
  // S_ISSUE | replaying the batch, one word per cycle, busy ignored

  localparam int DEPTH = 2 ** FIFO_AWIDTH;
  localparam int WW    = CFG_AWIDTH + CFG_DWIDTH;
  localparam logic [FIFO_AWIDTH:0] OCC_LAST = {1'b0, {FIFO_AWIDTH{1'b1}}};
  localparam logic [FIFO_AWIDTH:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WW-1:0]          mem_q [DEPTH];
  logic [WW-1:0]          mem_d [DEPTH];
  logic [FIFO_AWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AWIDTH:0]   pend_len_q, pend_len_d;
  logic [FIFO_AWIDTH:0]   batch_len_q, batch_len_d;
  logic [WW-1:0]          cfg_word_q, cfg_word_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   batch_done_q, batch_done_d;
  logic                   err_trunc_q, err_trunc_d;
  logic                   live_q, live_d;

  logic [FIFO_AWIDTH:0]   occ;
  logic                   full, push, pop, close, start, issue_end;

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign full      = occ[FIFO_AWIDTH];
  assign push      = up_val & up_rdy;
  assign close     = (state_q == S_FILL) & push & (up_last | (occ == OCC_LAST));
  assign start     = (state_q == S_WAIT) & ~engine_busy;
  assign issue_end = (state_q == S_ISSUE) & (occ == '0);
  assign pop       = start | ((state_q == S_ISSUE) & (occ != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (close)     state_d = S_WAIT;
      S_WAIT:  if (start)     state_d = S_ISSUE;
      S_ISSUE: if (issue_end) state_d = S_FILL;
      default:                state_d = S_FILL;
    endcase
  end

  always_comb begin
    // live_q keeps up_rdy low until the first edge after reset release
    live_d       = 1'b1;
    up_rdy       = live_q & (state_q == S_FILL) & ~full;
    cfg_valid_d  = pop;
    cfg_word_d   = pop ? mem_q[rd_ptr_q[FIFO_AWIDTH-1:0]] : cfg_word_q;
    batch_done_d = issue_end;
    pend_len_d   = start ? occ : pend_len_q;
    batch_len_d  = issue_end ? pend_len_q : batch_len_q;
    err_trunc_d  = err_trunc_q | (close & ~up_last);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[FIFO_AWIDTH-1:0]] = {up_addr, up_data};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_len_q   <= '0;
      batch_len_q  <= '0;
      cfg_word_q   <= '0;
      cfg_valid_q  <= 1'b0;
      batch_done_q <= 1'b0;
      err_trunc_q  <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_len_q   <= pend_len_d;
      batch_len_q  <= batch_len_d;
      cfg_word_q   <= cfg_word_d;
      cfg_valid_q  <= cfg_valid_d;
      batch_done_q <= batch_done_d;
      err_trunc_q  <= err_trunc_d;
      live_q       <= live_d;
    end
  end

  assign {cfg_addr, cfg_data} = cfg_word_q;
  assign cfg_valid  = cfg_valid_q;
  assign batch_done = batch_done_q;
  assign batch_len  = batch_len_q;
  assign err_trunc  = err_trunc_q;

endmodule

// File: tb/tb_cfg_sequencer.sv
// Bench for cfg_sequencer: directed batches then random traffic, every output checked
// each cycle against a queue-based batch model.
module tb_cfg_sequencer;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int FA    = 3;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] up_data = '0;
  logic [AW-1:0] up_addr = '0;
  logic          up_last = 1'b0;
  logic          up_val = 1'b0;
  logic          up_rdy;
  logic          engine_busy = 1'b0;
  logic [DW-1:0] cfg_data;
  logic [AW-1:0] cfg_addr;
  logic          cfg_valid;
  logic          batch_done;
  logic [FA:0]   batch_len;
  logic          err_trunc;

  cfg_sequencer #(.CFG_DWIDTH(DW), .CFG_AWIDTH(AW), .FIFO_AWIDTH(FA)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_addr(up_addr), .up_last(up_last), .up_val(up_val),
    .up_rdy(up_rdy), .engine_busy(engine_busy),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .batch_done(batch_done), .batch_len(batch_len), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  word_t hq[$];     // host words still to be offered
  word_t m_iss[$];  // words of the current batch not yet seen on the config bus
  bit    m_closed, m_issuing;
  int    m_blen;
  logic  exp_valid, exp_done, exp_err, exp_rdy;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] exp_addr;
  logic [FA:0]   exp_len;
  bit    acc;
  bit    gaps, busy_rand;
  logic  busy_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("cfg_valid",  64'(cfg_valid),  64'(exp_valid));
    check("cfg_data",   64'(cfg_data),   64'(exp_data));
    check("cfg_addr",   64'(cfg_addr),   64'(exp_addr));
    check("batch_done", 64'(batch_done), 64'(exp_done));
    check("batch_len",  64'(batch_len),  64'(exp_len));
    check("err_trunc",  64'(err_trunc),  64'(exp_err));
    check("up_rdy",     64'(up_rdy),     64'(exp_rdy));
  endtask

  task automatic model_reset();
    m_iss.delete();
    m_closed  = 0;
    m_issuing = 0;
    m_blen    = 0;
    exp_valid = 0; exp_done = 0; exp_err = 0; exp_rdy = 0;
    exp_data  = '0; exp_addr = '0; exp_len = '0;
  endtask

  task automatic emit();
    word_t w;
    w = m_iss.pop_front();
    exp_valid = 1;
    exp_data  = w.data;
    exp_addr  = w.addr;
  endtask

  // Applies the inputs present before the coming edge; leaves expectations for the next cycle.
  task automatic model_step();
    word_t w;
    w = '{addr: up_addr, data: up_data, last: up_last};
    acc = up_val && exp_rdy;
    exp_valid = 0;
    exp_done  = 0;
    if (!m_closed) begin
      if (acc) begin
        m_iss.push_back(w);
        if (w.last || m_iss.size() == DEPTH) begin
          if (!w.last) exp_err = 1;
          m_closed = 1;
          m_blen   = m_iss.size();
        end
      end
    end else if (!m_issuing) begin
      if (!engine_busy) begin
        m_issuing = 1;
        emit();
      end
    end else if (m_iss.size() > 0) begin
      emit();
    end else begin
      exp_done  = 1;
      exp_len   = m_blen[FA:0];
      m_closed  = 0;
      m_issuing = 0;
    end
    exp_rdy = !m_closed;
  endtask

  task automatic drive();
    bit hold;
    hold = up_val && !acc;
    if (acc) void'(hq.pop_front());
    if (hq.size() > 0) begin
      up_val  = hold ? 1'b1 : (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      up_addr = hq[0].addr;
      up_data = hq[0].data;
      up_last = hq[0].last;
    end else begin
      up_val  = 1'b0;
      up_last = 1'b0;
    end
    engine_busy = busy_rand ? ($urandom_range(0, 2) == 0) : busy_val;
    acc = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic add_word(input int a, input int d, input bit l);
    word_t w;
    w.addr = a[AW-1:0];
    w.data = d[DW-1:0];
    w.last = l;
    hq.push_back(w);
  endtask

  task automatic set_busy(input logic v);
    busy_val    = v;
    engine_busy = v;
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases between edges.
  task automatic do_reset();
    #2;
    rst    = 1'b0;
    up_val = 1'b0;
    hq.delete();
    acc = 0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_rdy = 1;
    drive();
  endtask

  initial begin
    int len;
    int guard;
    gaps = 0; busy_rand = 0; busy_val = 1'b0;
    do_reset();

    // three-word batch into an idle engine
    add_word(1, 'hA, 0); add_word(2, 'hB, 0); add_word(3, 'hC, 1);
    drive();
    run(10);
    check("t1_len", 64'(batch_len), 64'(3));

    // batch held back while the engine is busy
    add_word(4, 'h1111, 0); add_word(5, 'h2222, 1);
    set_busy(1'b1);
    drive();
    run(14);
    set_busy(1'b0);
    run(8);
    check("t2_len", 64'(batch_len), 64'(2));

    // nine words without last: truncation at depth, ninth word starts the next batch
    for (int i = 0; i < 9; i++) add_word(i + 8, 'h100 + i, 0);
    add_word(20, 'h200, 1);
    drive();
    run(30);
    check("t3_err", 64'(err_trunc), 64'(1));
    check("t3_len", 64'(batch_len), 64'(2));

    // busy rising during issue must not stall the beats
    for (int i = 0; i < 5; i++) add_word(i + 21, 'h300 + i, i == 4);
    drive();
    run(6);
    set_busy(1'b1);
    run(8);
    set_busy(1'b0);
    check("t4_len", 64'(batch_len), 64'(5));

    // reset during the second beat of four
    for (int i = 0; i < 4; i++) add_word(i + 1, 'h400 + i, i == 3);
    drive();
    run(6);
    check("t5_beat2", 64'(cfg_data), 64'('h401));
    do_reset();
    run(10);

    // second batch offered while the first is in flight
    for (int i = 0; i < 4; i++) add_word(i + 2, 'h500 + i, i == 3);
    for (int i = 0; i < 3; i++) add_word(i + 9, 'h600 + i, i == 2);
    drive();
    run(25);
    check("t6_len", 64'(batch_len), 64'(3));

    // random traffic: random batch lengths (some truncating), gaps and busy
    gaps = 1; busy_rand = 1;
    for (int c = 0; c < 400; c++) begin
      if (hq.size() < 3) begin
        len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++)
          add_word($urandom_range(0, 31), $urandom(), i == len - 1);
      end
      cycle();
    end
    gaps = 0; busy_rand = 0;
    set_busy(1'b0);
    guard = 0;
    while ((hq.size() > 0 || m_closed) && guard < 300) begin
      cycle();
      guard++;
    end
    run(3);
    check("drain_timeout", 64'(hq.size() == 0 && !m_closed), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
